// File: rtl/fir_tm_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC core.
// Holds the FSM state encoding, clog2, and the shift/saturate helpers used on the accumulator and output paths.
package fir_tm_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Arithmetic right shift by 'drop' bits (floor), then clamp to a w-bit signed range.
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                   input int drop, input int w);
        logic signed [63:0] s, hi, lo;
        s  = v >>> drop;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

    function automatic logic sat_flag(input logic signed [63:0] v,
                                      input int drop, input int w);
        return sat_val(v, drop, w) != (v >>> drop);
    endfunction

endpackage

// File: rtl/fir_tm_sat_acc.sv
// Saturating accumulate-and-clear register.
// 'ovf' flags that the current accumulate step clamped.
module fir_tm_sat_acc
    import fir_tm_pkg::*;
#(
    parameter int W    = 20,
    parameter int WADD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            en,
    input  logic [WADD-1:0] addend,
    output logic [W-1:0]    acc,
    output logic            ovf
);

    logic signed [63:0] sum_raw;

    always_comb begin
        sum_raw = 64'($signed(acc)) + 64'($signed(addend));
        ovf     = en & sat_flag(sum_raw, 0, W);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) acc <= '0;
        else if (en)      acc <= W'(sat_val(sum_raw, 0, W));
    end

endmodule

// File: rtl/fir_tm_mac.sv
// Time-multiplexed FIR core: one tap per clock through an external multiplier,
// saturating accumulation, one output strobe per accepted sample.
module fir_tm_mac
    import fir_tm_pkg::*;
#(
    parameter int NTAP = 8,
    parameter int WI   = 4,
    parameter int WF   = 4,
    parameter int WIP  = 8,
    parameter int WFP  = 8,
    parameter int WIA  = 12,
    parameter int WIO  = 8,
    parameter int WFO  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WI+WF-1:0]       in_data,
    input  logic                   coef_we,
    input  logic [clog2(NTAP)-1:0] coef_addr,
    input  logic [WI+WF-1:0]       coef_wdata,
    output logic [WI+WF-1:0]       mul_a,
    output logic [WI+WF-1:0]       mul_b,
    input  logic [WIP+WFP-1:0]     mul_p,
    input  logic                   mul_ovf,
    output logic                   out_valid,
    output logic [WIO+WFO-1:0]     out_data,
    output logic                   out_ovf
);

    localparam int WS = WI + WF;
    localparam int WA = WIA + WFP;
    localparam int WO = WIO + WFO;
    localparam int AW = clog2(NTAP);

    state_t             state, state_nxt;
    logic [AW-1:0]      k;
    logic [WS-1:0]      x    [NTAP];
    logic [WS-1:0]      coef [NTAP];
    logic               ovf_sticky;
    logic [WA-1:0]      acc;
    logic               acc_ovf;
    logic               accept, in_mac, last_tap;
    logic signed [63:0] acc_wide;

    assign accept   = (state == IDLE) && in_valid;
    assign in_mac   = (state == MAC);
    assign last_tap = (k == AW'(NTAP - 1));
    assign acc_wide = 64'($signed(acc));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC:  if (last_tap) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the delay line and coefficient bank are flop arrays with a real reset, not RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            ovf_sticky <= 1'b0;
            for (int i = 0; i < NTAP; i++) x[i] <= '0;
        end else if (accept) begin
            x[0]       <= in_data;
            for (int i = 1; i < NTAP; i++) x[i] <= x[i-1];
            k          <= '0;
            ovf_sticky <= 1'b0;
        end else if (in_mac) begin
            ovf_sticky <= ovf_sticky | mul_ovf | acc_ovf;
            if (!last_tap) k <= k + 1'b1;
        end
    end

    // A write lands at the edge, so a same-cycle read of that tap still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) coef[i] <= '0;
        end else if (coef_we) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    assign mul_a = in_mac ? x[k]    : '0;
    assign mul_b = in_mac ? coef[k] : '0;

    fir_tm_sat_acc #(.W(WA), .WADD(WIP + WFP)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .en     (in_mac),
        .addend (mul_p),
        .acc    (acc),
        .ovf    (acc_ovf)
    );

    assign out_data = out_valid ? WO'(sat_val(acc_wide, WFP - WFO, WO)) : '0;
    assign out_ovf  = out_valid & (ovf_sticky | sat_flag(acc_wide, WFP - WFO, WO));

endmodule
